param_reg_file: RTL
===================

# param_reg_file

Parametrised general-purpose register file: DEPTH registers of WIDTH bits, two combinational read ports, one broadcast write/function port driven by a per-register enable mask. Successor to the fixed 8-bit, four-register file used in the datapath; adds configurable width and depth, shift and half-load functions, selectable wrap or saturate arithmetic, and per-register sticky overflow flags. Sits between the ALU result bus and the ALU operand muxes.

## Interface
- WIDTH, 8, register width in bits; even, ≥ 4
- DEPTH, 8, number of registers; ≥ 2
- SAT, 0, 0 = increment/decrement wrap, 1 = saturate at 0 / 2^WIDTH−1
- SELW, $clog2(DEPTH), read-select width (derived, do not override)
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all registers and flags
- in  in  WIDTH  write data
- fun_sel  in  3  function applied to every enabled register
- reg_sel  in  DEPTH  enable mask; bit i enables register i
- O1Sel  in  SELW  read port 1 select
- O2Sel  in  SELW  read port 2 select
- O1  out  WIDTH  contents of register O1Sel
- O2  out  WIDTH  contents of register O2Sel
- ovf  out  DEPTH  sticky overflow flag, one per register

## Operation
- fun_sel encoding, applied to each register i with reg_sel[i]=1; registers with reg_sel[i]=0 retain value and flag:
  - 000 clear: R=0, ovf[i]=0
  - 001 load: R=in
  - 010 decrement: R=R−1
  - 011 increment: R=R+1
  - 100 shift left logical: R={R[WIDTH−2:0],0}; ovf[i] set if old R[WIDTH−1]=1
  - 101 shift right logical: R={0,R[WIDTH−1:1]}; ovf unaffected
  - 110 load low half: R[WIDTH/2−1:0]=in[WIDTH/2−1:0], high half retained
  - 111 load high half: R[WIDTH−1:WIDTH/2]=in[WIDTH/2−1:0], low half retained
- Increment at 2^WIDTH−1: SAT=0 → R=0; SAT=1 → R stays 2^WIDTH−1; ovf[i] set in both modes.
- Decrement at 0: SAT=0 → R=2^WIDTH−1; SAT=1 → R stays 0; ovf[i] set in both modes.
- ovf[i] is sticky: only reset or a clear of register i returns it to 0; load/half-load/shift-right leave it unchanged.
- Multiple reg_sel bits set: all enabled registers perform the same function independently on their own contents in the same cycle; reg_sel=0 is a no-op.
- Read ports are combinational muxes of current register contents; O1Sel ≥ DEPTH (non-power-of-two DEPTH) → output 0.

## Timing
- Reset: synchronous, priority over fun_sel/reg_sel; after the reset edge all registers = 0, O1 = O2 = 0, ovf = 0. Before the first reset edge contents are undefined.
- Write latency 1 cycle: function result visible on O1/O2 and ovf immediately after the rising edge it was sampled on.
- Read-during-write to the same register: O1/O2 show the pre-edge value until the edge, new value after; no bypass.
- Reset asserted mid-sequence: the operation presented that cycle is discarded.
- No handshake; every enabled op completes in one cycle, back-to-back ops every cycle.

## Test plan
- WIDTH=8, DEPTH=8, SAT=0: reset 1 cycle, then load 0x05 with reg_sel=0xFF; O1Sel=3, O2Sel=7 → O1=O2=0x05, ovf=0x00.
- Increment reg 2 from 0xFF (load 0xFF, then fun 011, reg_sel=0x04) → R2=0x00, ovf=0x04; following load 0x10 to R2 → R2=0x10, ovf still 0x04; clear R2 → ovf=0x00.
- SAT=1 instance: decrement R0 from 0x00 → R0=0x00, ovf[0]=1; increment R1 from 0xFF → R1=0xFF, ovf[1]=1.
- Half loads on R4 holding 0x00: fun 110 in=0x0A → 0x0A; fun 111 in=0x0C → 0xCA; shift left on 0xCA → 0x94, ovf[4]=1; shift right on 0x94 → 0x4A.
- reg_sel=0x00 with fun 001 in=0xFF → all registers unchanged; same-cycle read of register being loaded shows old value, new value next cycle.
- Reset asserted in the same cycle as load 0xAA to all → all registers 0x00, ovf=0x00; DEPTH=6 instance with O1Sel=7 → O1=0x00.

Source files
------------

// File: rtl/param_reg_file.sv
// param_reg_file: DEPTH x WIDTH register file with broadcast masked functions, two read ports, sticky overflow flags.
module param_reg_file #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int SAT   = 0,
    parameter int SELW  = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       fun_sel,
    input  logic [DEPTH-1:0] reg_sel,
    input  logic [SELW-1:0]  O1Sel,
    input  logic [SELW-1:0]  O2Sel,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [DEPTH-1:0] ovf
);
    localparam int H = WIDTH / 2;
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [SELW:0] DEPTH_W = DEPTH[SELW:0];

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] ovf_q, ovf_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            ovf_d[i]  = ovf_q[i];
            if (reg_sel[i]) begin
                case (fun_sel)
                    3'b000: begin
                        regs_d[i] = '0;
                        ovf_d[i]  = 1'b0;
                    end
                    3'b001: regs_d[i] = in;
                    3'b010: begin
                        regs_d[i] = (regs_q[i] == '0) ? ((SAT != 0) ? '0 : MAX) : regs_q[i] - 1'b1;
                        ovf_d[i]  = ovf_q[i] | (regs_q[i] == '0);
                    end
                    3'b011: begin
                        regs_d[i] = (regs_q[i] == MAX) ? ((SAT != 0) ? MAX : '0) : regs_q[i] + 1'b1;
                        ovf_d[i]  = ovf_q[i] | (regs_q[i] == MAX);
                    end
                    3'b100: begin
                        regs_d[i] = {regs_q[i][WIDTH-2:0], 1'b0};
                        ovf_d[i]  = ovf_q[i] | regs_q[i][WIDTH-1];
                    end
                    3'b101: regs_d[i] = {1'b0, regs_q[i][WIDTH-1:1]};
                    3'b110: regs_d[i][H-1:0] = in[H-1:0];
                    3'b111: regs_d[i][WIDTH-1:H] = in[H-1:0];
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            ovf_q <= '0;
        end else begin
            regs_q <= regs_d;
            ovf_q  <= ovf_d;
        end
    end

    // Selects beyond DEPTH only exist for non-power-of-two depths and read as zero.
    assign O1  = ({1'b0, O1Sel} < DEPTH_W) ? regs_q[O1Sel] : '0;
    assign O2  = ({1'b0, O2Sel} < DEPTH_W) ? regs_q[O2Sel] : '0;
    assign ovf = ovf_q;
endmodule
